// File: rtl/clk_root_div.sv
// Glitch-free programmable clock divider with a graceful drain on disable,
// ratio updates that take effect at a falling edge, and a rising-edge counter.
module clk_root_div #(
    parameter int RATIO_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_req,
    output logic               en_ack,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [RATIO_W-1:0] cfg_ratio,
    output logic               clk_out,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   edge_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic               r_clk_out;
    logic               r_en_ack;
    logic [RATIO_W-1:0] r_phase;
    logic [RATIO_W-1:0] r_ratio_act;
    logic [RATIO_W-1:0] r_pend_ratio;
    logic               r_pend_vld;
    logic [CNT_W-1:0]   r_edge_cnt;

    logic [1:0]         w_state_nxt;
    logic               w_clk_nxt;
    logic [RATIO_W-1:0] w_phase_nxt;
    logic               w_tgl;
    logic               w_rise;
    logic               w_fall;
    logic               w_xfer;

    assign w_tgl  = (r_phase == r_ratio_act);
    assign w_xfer = cfg_valid & ~r_pend_vld;

    always_comb begin
        w_state_nxt = r_state;
        w_clk_nxt   = r_clk_out;
        w_phase_nxt = r_phase;
        case (r_state)
            ST_IDLE: begin
                w_clk_nxt   = 1'b0;
                w_phase_nxt = '0;
                if (en_req) begin
                    w_state_nxt = ST_RUN;
                    w_clk_nxt   = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_tgl) begin
                    w_phase_nxt = '0;
                    w_clk_nxt   = ~r_clk_out;
                end else begin
                    w_phase_nxt = r_phase + RATIO_W'(1);
                end
                if (!en_req)
                    w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_tgl) begin
                    w_phase_nxt = '0;
                    // The rising toggle is swallowed: park in IDLE with the output low.
                    if (r_clk_out)
                        w_clk_nxt = 1'b0;
                    else
                        w_state_nxt = ST_IDLE;
                end else begin
                    w_phase_nxt = r_phase + RATIO_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_clk_nxt   = 1'b0;
                w_phase_nxt = '0;
            end
        endcase
    end

    assign w_rise = ~r_clk_out & w_clk_nxt;
    assign w_fall = r_clk_out & ~w_clk_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_clk_out <= 1'b0;
            r_phase   <= '0;
            r_en_ack  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_out <= w_clk_nxt;
            r_phase   <= w_phase_nxt;
            r_en_ack  <= (r_state == ST_RUN);
        end
    end

    // Ratio changes only land where the phase counter restarts, so no short pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ratio_act  <= '0;
            r_pend_ratio <= '0;
            r_pend_vld   <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_xfer) begin
                r_ratio_act <= cfg_ratio;
            end else if (r_pend_vld) begin
                r_ratio_act <= r_pend_ratio;
                r_pend_vld  <= 1'b0;
            end
        end else begin
            if (w_fall && r_pend_vld) begin
                r_ratio_act <= r_pend_ratio;
                r_pend_vld  <= 1'b0;
            end
            if (w_xfer) begin
                r_pend_ratio <= cfg_ratio;
                r_pend_vld   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_edge_cnt <= '0;
        else if (cnt_clr)
            r_edge_cnt <= '0;
        else if (w_rise)
            r_edge_cnt <= r_edge_cnt + CNT_W'(1);
    end

    assign clk_out   = r_clk_out;
    assign en_ack    = r_en_ack;
    assign cfg_ready = ~r_pend_vld;
    assign edge_cnt  = r_edge_cnt;

endmodule

// File: tb/tb_clk_root_div.sv
// Bench for clk_root_div: expected clk_out waveform is queued as stimulus is
// applied and compared each falling clk edge; point checks cover the rest.
module tb_clk_root_div;

    localparam int RATIO_W = 4;
    // Narrow counter so the wrap point is reachable in a short run.
    localparam int CNT_W   = 8;

    logic               clk;
    logic               rst_n;
    logic               en_req;
    logic               en_ack;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [RATIO_W-1:0] cfg_ratio;
    logic               clk_out;
    logic               cnt_clr;
    logic [CNT_W-1:0]   edge_cnt;

    int   n_chk = 0;
    int   n_err = 0;
    logic sb_q[$];

    clk_root_div #(.RATIO_W(RATIO_W), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_req    (en_req),
        .en_ack    (en_ack),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ratio (cfg_ratio),
        .clk_out   (clk_out),
        .cnt_clr   (cnt_clr),
        .edge_cnt  (edge_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_lvl(input logic v, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(v);
    endtask

    task automatic drain_sb();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic do_reset();
        drain_sb();
        rst_n     = 1'b0;
        en_req    = 1'b0;
        cfg_valid = 1'b0;
        cnt_clr   = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin : mon
            logic e;
            e = sb_q.pop_front();
            check("clk_out", 32'(clk_out), 32'(e));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; en_req = 1'b0; cfg_valid = 1'b0; cfg_ratio = '0; cnt_clr = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_en_ack", 32'(en_ack), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_edge_cnt", 32'(edge_cnt), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // R=3 accepted in IDLE, 10 periods of 4 high / 4 low
        cfg_valid = 1'b1; cfg_ratio = 4'd3;
        check("a_rdy_idle", 32'(cfg_ready), 32'd1);
        step(1);
        cfg_valid = 1'b0;
        check("a_rdy_after", 32'(cfg_ready), 32'd1);
        en_req = 1'b1;
        push_lvl(1'b0, 1);
        for (int p = 0; p < 10; p++) begin
            push_lvl(1'b1, 4);
            push_lvl(1'b0, 4);
        end
        step(1);
        check("a_ack_entry", 32'(en_ack), 32'd0);
        step(1);
        check("a_ack_run", 32'(en_ack), 32'd1);
        step(78);
        check("a_edge_cnt", 32'(edge_cnt), 32'd10);

        // R=1 running, R=5 offered mid-high, then R=2 offered on a falling toggle
        do_reset();
        cfg_valid = 1'b1; cfg_ratio = 4'd1;
        step(1);
        cfg_valid = 1'b0;
        en_req = 1'b1;
        push_lvl(1'b0, 1);
        push_lvl(1'b1, 2); push_lvl(1'b0, 2); push_lvl(1'b1, 2);
        push_lvl(1'b0, 6); push_lvl(1'b1, 6); push_lvl(1'b0, 6); push_lvl(1'b1, 6);
        push_lvl(1'b0, 3); push_lvl(1'b1, 3);
        step(5);
        cfg_valid = 1'b1; cfg_ratio = 4'd5;
        check("b_rdy_offer", 32'(cfg_ready), 32'd1);
        step(1);
        cfg_valid = 1'b0;
        check("b_rdy_pend", 32'(cfg_ready), 32'd0);
        step(1);
        check("b_rdy_fall", 32'(cfg_ready), 32'd1);
        step(11);
        cfg_valid = 1'b1; cfg_ratio = 4'd2;
        step(1);
        cfg_valid = 1'b0;
        check("b_rdy_coinc", 32'(cfg_ready), 32'd0);
        step(12);
        check("b_rdy_load", 32'(cfg_ready), 32'd1);

        // R=2, en_req dropped in 2nd high cycle; drain to IDLE then restart
        do_reset();
        cfg_valid = 1'b1; cfg_ratio = 4'd2;
        step(1);
        cfg_valid = 1'b0;
        en_req = 1'b1;
        push_lvl(1'b0, 1);
        push_lvl(1'b1, 3); push_lvl(1'b0, 3); push_lvl(1'b0, 3);
        step(2);
        en_req = 1'b0;
        step(1);
        check("c_ack_hold", 32'(en_ack), 32'd1);
        step(1);
        check("c_ack_drop", 32'(en_ack), 32'd0);
        step(5);
        en_req = 1'b1;
        push_lvl(1'b1, 3); push_lvl(1'b0, 1);
        step(4);

        // R=0, one-cycle en_req glitch: full drain, one IDLE cycle, restart
        do_reset();
        en_req = 1'b1;
        sb_q.push_back(1'b0);
        sb_q.push_back(1'b1); sb_q.push_back(1'b0); sb_q.push_back(1'b1);
        sb_q.push_back(1'b0); sb_q.push_back(1'b0);
        sb_q.push_back(1'b1); sb_q.push_back(1'b0); sb_q.push_back(1'b1);
        sb_q.push_back(1'b0);
        step(3);
        en_req = 1'b0;
        step(1);
        en_req = 1'b1;
        step(1);
        check("d_ack_drain", 32'(en_ack), 32'd0);
        step(2);
        check("d_ack_rerun", 32'(en_ack), 32'd1);
        step(1);
        check("d_edge_cnt", 32'(edge_cnt), 32'd4);

        // edge counter wrap and clear-beats-increment, R=0
        do_reset();
        en_req = 1'b1;
        step(510);
        check("e_cnt_max", 32'(edge_cnt), 32'hFF);
        step(1);
        check("e_cnt_wrap", 32'(edge_cnt), 32'd0);
        step(5);
        check("e_cnt_two", 32'(edge_cnt), 32'd2);
        cnt_clr = 1'b1;
        step(1);
        check("e_cnt_clr", 32'(edge_cnt), 32'd0);
        cnt_clr = 1'b0;
        step(2);
        check("e_cnt_resume", 32'(edge_cnt), 32'd1);

        // async reset while clk_out high in RUN with R=2, restart at R=0
        do_reset();
        cfg_valid = 1'b1; cfg_ratio = 4'd2;
        step(1);
        cfg_valid = 1'b0;
        en_req = 1'b1;
        step(8);
        check("f_pre_clk", 32'(clk_out), 32'd1);
        check("f_pre_cnt", 32'(edge_cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        check("f_rst_clk", 32'(clk_out), 32'd0);
        check("f_rst_ack", 32'(en_ack), 32'd0);
        check("f_rst_cnt", 32'(edge_cnt), 32'd0);
        check("f_rst_rdy", 32'(cfg_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.push_back(1'b0);
        sb_q.push_back(1'b1); sb_q.push_back(1'b0);
        sb_q.push_back(1'b1); sb_q.push_back(1'b0);
        step(2);
        check("f_ack_run", 32'(en_ack), 32'd1);
        step(1);
        check("f_cnt_run", 32'(edge_cnt), 32'd2);
        drain_sb();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/clk_root_div.md
CLK_ROOT_DIV -- requirements
Module: clk_root_div

Interface
REQ-001 Parameter: RATIO_W, default 4, width of divide-ratio field.
REQ-002 Parameter: CNT_W, default 16, width of rising-edge counter.
REQ-003 Port: clk  input  1  block clock; sole clock domain; every flop is rising-edge clocked.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: en_req  input  1  level request to run the divided clock.
REQ-006 Port: en_ack  output  1  high while divided clock is running (state RUN).
REQ-007 Port: cfg_valid  input  1  new ratio offered.
REQ-008 Port: cfg_ready  output  1  ratio can be accepted.
REQ-009 Port: cfg_ratio  input  RATIO_W  half-period minus one, in clk cycles.
REQ-010 Port: clk_out  output  1  divided, glitch-free clock; drives the downstream flop-sink clock tree; driven directly from a flop.
REQ-011 Port: cnt_clr  input  1  synchronous clear of edge_cnt.
REQ-012 Port: edge_cnt  output  CNT_W  count of clk_out rising edges.

Function
REQ-013 The block SHALL hold the active ratio R in ratio_act; each clk_out high and low phase SHALL last exactly R+1 clk cycles, giving period 2*(R+1).
REQ-014 The block SHALL implement states IDLE, RUN and DRAIN; clk_out SHALL be 0 throughout IDLE.
REQ-015 IDLE with en_req=1 sampled SHALL move to RUN next cycle with clk_out=1 and phase counter=0.
REQ-016 In RUN/DRAIN, the phase counter SHALL increment each cycle; when it equals ratio_act it SHALL reset to 0 and clk_out SHALL toggle.
REQ-017 RUN with en_req=0 sampled SHALL move to DRAIN without altering clk_out or the phase counter.
REQ-018 DRAIN SHALL complete the current high phase (if any) and the following full low phase, then enter IDLE on the cycle the rising toggle would occur, with clk_out remaining 0.
REQ-019 en_req reasserted during DRAIN SHALL NOT abort DRAIN; after IDLE is entered, REQ-015 applies, guaranteeing a low phase of at least R+2 cycles.
REQ-020 en_ack SHALL equal (state==RUN), registered.
REQ-021 A cfg transfer SHALL occur when cfg_valid and cfg_ready are both 1; cfg_ready SHALL be 0 while a pending ratio is held.
REQ-022 In IDLE, an accepted ratio SHALL load ratio_act on the next cycle and leave nothing pending.
REQ-023 In RUN/DRAIN, an accepted ratio SHALL be held pending and loaded into ratio_act on the cycle clk_out toggles high-to-low; cfg_ready SHALL return to 1 the same cycle.
REQ-024 A cfg transfer and a falling toggle in the same cycle SHALL leave the new ratio pending (it does not take effect in that toggle).
REQ-025 edge_cnt SHALL increment on every cycle in which clk_out goes 0->1, wrapping from 2^CNT_W-1 to 0.
REQ-026 cnt_clr SHALL zero edge_cnt and take priority over a simultaneous increment.
REQ-027 clk_out SHALL never produce a high or low pulse shorter than R+1 cycles for the ratio in effect when the pulse began.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: state IDLE, clk_out 0, en_ack 0, cfg_ready 1, pending cleared, ratio_act 0, phase counter 0, edge_cnt 0.
REQ-029 Reset asserted mid-phase SHALL drop clk_out to 0 immediately; after release, the block SHALL behave as freshly reset (en_req must be sampled in IDLE).

Verification
REQ-030 Reset, cfg_ratio=3 accepted in IDLE, en_req=1 -> clk_out high 4 / low 4 cycles, en_ack=1 one cycle after RUN entry, edge_cnt=10 after 10 periods.
REQ-031 R=1 running, cfg_ratio=5 offered mid-high-phase -> cfg_ready=0 until falling edge; next low and all later phases last 6 cycles.
REQ-032 R=2, en_req dropped on 2nd cycle of high phase -> high completes (3 cycles), low lasts 3, then IDLE with clk_out 0; en_ack drops 1 cycle after en_req sampled low.
REQ-033 en_req pulsed 0 for 1 cycle then 1 during RUN, R=0 -> full DRAIN, IDLE for 1 cycle, restart; no clk_out pulse shorter than 1 cycle low / 1 cycle high.
REQ-034 edge_cnt preloaded via run to 0xFFFF, one more rising edge -> 0x0000; cnt_clr coincident with a rising edge -> 0x0000.
REQ-035 rst_n asserted while clk_out=1 in RUN -> clk_out, en_ack, edge_cnt 0 asynchronously; release with en_req=1 -> RUN after one IDLE cycle, R=0.
